sa_compute_sequencer: RTL and testbench

- Sequences one matrix-multiply pass of the systolic array (SA) behind the SA AXI4 slave.
- Accepts a command: weight, input and output buffer base addresses plus a row count.
- Preloads SA_DIM weight rows from the weight buffer, then streams input vectors from the input buffer, then collects result vectors into the output buffer.
- Sits between the AXI4-slave register/buffer bank and the SA core, and is the only driver of the SA control strobes.

---
 rtl/sa_compute_sequencer.sv | 162 ++++++++++++++++
 tb/tb_sa_compute_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_compute_sequencer.sv
// sa_compute_sequencer
//   Sequences one matrix-multiply pass of the systolic array. It preloads
//   SA_DIM weight rows, then streams N input vectors, then collects N result
//   vectors into the output buffer. It is the only driver of the SA control
//   strobes.
//
// Ports
//   ACLK, ARESET                  clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready           command handshake; ready only while idle
//   cmd_w/x/y_addr, cmd_rows      buffer bases and number of input vectors
//   stall                         holds issue; in-flight strobes still land
//   wbuf_rd_en/addr, sa_load_w    weight read and SA shift-in (1-cycle lag)
//   xbuf_rd_en/addr, sa_x_valid   input read and SA vector valid (1-cycle lag)
//   sa_y_valid                    SA result valid; never back-pressured
//   ybuf_wr_en/addr               result write, same cycle as sa_y_valid
//   busy, done, err               status; done pulses once, err is sticky
module sa_compute_sequencer #(
    parameter int SA_DIM        = 8,
    parameter int ADDR_W        = 10,
    parameter int LEN_W         = 8,
    parameter int DRAIN_TIMEOUT = 32
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_w_addr,
    input  logic [ADDR_W-1:0] cmd_x_addr,
    input  logic [ADDR_W-1:0] cmd_y_addr,
    input  logic [LEN_W-1:0]  cmd_rows,
    input  logic              stall,
    output logic              wbuf_rd_en,
    output logic [ADDR_W-1:0] wbuf_rd_addr,
    output logic              sa_load_w,
    output logic              xbuf_rd_en,
    output logic [ADDR_W-1:0] xbuf_rd_addr,
    output logic              sa_x_valid,
    input  logic              sa_y_valid,
    output logic              ybuf_wr_en,
    output logic [ADDR_W-1:0] ybuf_wr_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int KW = (SA_DIM > 1) ? $clog2(SA_DIM) : 1;
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [KW-1:0] K_LAST = KW'(SA_DIM - 1);
    localparam logic [TW-1:0] T_LAST = TW'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] w_addr, x_addr, y_addr;
    logic [LEN_W-1:0]  rows;
    logic [KW-1:0]     k;
    logic [LEN_W-1:0]  i;
    logic [LEN_W-1:0]  j;
    logic [TW-1:0]     tmo;
    logic              accept, tmo_hit, collect, y_extra;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        wbuf_rd_en = 1'b0;
        xbuf_rd_en = 1'b0;
        accept     = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = (cmd_rows == '0) ? S_DONE : S_LOAD_W;
                end
            end
            S_LOAD_W: if (!stall) begin
                wbuf_rd_en = 1'b1;
                if (k == K_LAST) state_nxt = S_STREAM;
            end
            S_STREAM: if (!stall) begin
                xbuf_rd_en = 1'b1;
                if (i == rows - LEN_W'(1)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // j is registered, so this exits the cycle after the final write.
                if (j == rows) begin
                    state_nxt = S_DONE;
                end else if (!sa_y_valid && tmo == T_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Results are accepted in every active state; ones beyond N are dropped.
    assign collect    = sa_y_valid && (state != S_IDLE);
    assign ybuf_wr_en = collect && (j != rows);
    assign y_extra    = collect && (j == rows);

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    assign wbuf_rd_addr = w_addr + ADDR_W'(k);
    assign xbuf_rd_addr = x_addr + ADDR_W'(i);
    assign ybuf_wr_addr = y_addr + ADDR_W'(j);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_addr     <= '0;
            x_addr     <= '0;
            y_addr     <= '0;
            rows       <= '0;
            k          <= '0;
            i          <= '0;
            j          <= '0;
            tmo        <= '0;
            err        <= 1'b0;
            sa_load_w  <= 1'b0;
            sa_x_valid <= 1'b0;
        end else begin
            // Buffer read latency is one cycle; the SA strobes follow the reads.
            sa_load_w  <= wbuf_rd_en;
            sa_x_valid <= xbuf_rd_en;

            if (accept) begin
                w_addr <= cmd_w_addr;
                x_addr <= cmd_x_addr;
                y_addr <= cmd_y_addr;
                rows   <= cmd_rows;
                k      <= '0;
                i      <= '0;
                j      <= '0;
                tmo    <= '0;
                err    <= (cmd_rows == '0);
            end else begin
                if (wbuf_rd_en) k <= (k == K_LAST) ? '0 : k + KW'(1);
                if (xbuf_rd_en) i <= i + LEN_W'(1);
                if (ybuf_wr_en) j <= j + LEN_W'(1);
                if (y_extra || tmo_hit) err <= 1'b1;
                if (state == S_DRAIN && !sa_y_valid) tmo <= tmo + TW'(1);
                else                                 tmo <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sa_compute_sequencer.sv
// tb_sa_compute_sequencer
//   Drives commands into sa_compute_sequencer with an SA responder that echoes
//   each sa_x_valid as sa_y_valid three cycles later (up to a reply budget).
//   A negedge monitor logs issued addresses; expected sequences come from
//   base+offset mod 2^ADDR_W.
module tb_sa_compute_sequencer;

    localparam int SA_DIM = 8;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 8;
    localparam int TMO    = 32;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_w_addr = '0, cmd_x_addr = '0, cmd_y_addr = '0;
    logic [LEN_W-1:0]  cmd_rows = '0;
    logic              stall = 1'b0;
    logic              wbuf_rd_en, sa_load_w, xbuf_rd_en, sa_x_valid, ybuf_wr_en;
    logic [ADDR_W-1:0] wbuf_rd_addr, xbuf_rd_addr, ybuf_wr_addr;
    logic              sa_y_valid;
    logic              busy, done, err;

    sa_compute_sequencer #(.SA_DIM(SA_DIM), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
                           .DRAIN_TIMEOUT(TMO)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_w_addr(cmd_w_addr), .cmd_x_addr(cmd_x_addr), .cmd_y_addr(cmd_y_addr),
        .cmd_rows(cmd_rows), .stall(stall),
        .wbuf_rd_en(wbuf_rd_en), .wbuf_rd_addr(wbuf_rd_addr), .sa_load_w(sa_load_w),
        .xbuf_rd_en(xbuf_rd_en), .xbuf_rd_addr(xbuf_rd_addr), .sa_x_valid(sa_x_valid),
        .sa_y_valid(sa_y_valid), .ybuf_wr_en(ybuf_wr_en), .ybuf_wr_addr(ybuf_wr_addr),
        .busy(busy), .done(done), .err(err)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0, errors = 0;
    int cyc = 0;
    int wq[$], wc[$], xq[$], yq[$], yc[$];
    int lw_cnt, xv_cnt, done_cnt, done_cyc, acc_cyc;
    int lag_bad = 0, rdy_bad = 0;
    logic err_done, err_after_acc;
    logic prev_w = 1'b0, prev_x = 1'b0;
    logic [3:0] hist;
    int replies_left = 0;

    function automatic int exp_addr(int base, int off);
        return (base + off) % (1 << ADDR_W);
    endfunction

    // Monitor
    initial forever begin
        @(negedge ACLK);
        cyc++;
        if (ARESET) begin
            prev_w = 1'b0;
            prev_x = 1'b0;
        end else begin
            if (sa_load_w !== prev_w || sa_x_valid !== prev_x) lag_bad++;
            if (cmd_ready !== !busy) rdy_bad++;
            if (cyc == acc_cyc + 1) err_after_acc = err;
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (wbuf_rd_en) begin wq.push_back(int'(wbuf_rd_addr)); wc.push_back(cyc); end
            if (xbuf_rd_en) xq.push_back(int'(xbuf_rd_addr));
            if (ybuf_wr_en) begin yq.push_back(int'(ybuf_wr_addr)); yc.push_back(cyc); end
            if (sa_load_w) lw_cnt++;
            if (sa_x_valid) xv_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; err_done = err; end
            prev_w = wbuf_rd_en;
            prev_x = xbuf_rd_en;
        end
    end

    // SA responder: result appears three cycles after the input vector.
    initial begin
        hist = '0;
        sa_y_valid = 1'b0;
        forever begin
            @(posedge ACLK);
            #1;
            hist = {hist[2:0], sa_x_valid};
            sa_y_valid = hist[3] && (replies_left > 0);
            if (sa_y_valid) replies_left--;
        end
    end

    // mode 0: no stall, 1: random stall, 2: stall 3 cycles when k=3 is due
    task automatic run_cmd(input int w, input int x, input int y, input int n,
                           input int replies, input int mode);
        int cnt, sc;
        wq.delete(); wc.delete(); xq.delete(); yq.delete(); yc.delete();
        lw_cnt = 0; xv_cnt = 0; done_cnt = 0; done_cyc = -1; acc_cyc = -10;
        err_done = 1'bx; err_after_acc = 1'bx;
        replies_left = replies;
        @(posedge ACLK); #1;
        cmd_w_addr = ADDR_W'(w); cmd_x_addr = ADDR_W'(x); cmd_y_addr = ADDR_W'(y);
        cmd_rows = LEN_W'(n); cmd_valid = 1'b1; stall = 1'b0;
        @(posedge ACLK); #1;
        cmd_valid = 1'b0;
        cnt = 0; sc = 0;
        while (done_cnt == 0 && cnt < 3000) begin
            if (mode == 1) stall = ($urandom_range(0, 99) < 30);
            else if (mode == 2 && wq.size() == 3 && sc < 3) begin stall = 1'b1; sc++; end
            else stall = 1'b0;
            @(posedge ACLK); #1;
            cnt++;
        end
        stall = 1'b0;
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL done_wait: no done within %0d cycles (n=%0d)", cnt, n);
        end
        repeat (4) @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] st;
        #1;
        st = {cmd_ready, busy, done, err, wbuf_rd_en, sa_load_w, xbuf_rd_en, sa_x_valid, ybuf_wr_en};
        checks++;
        if (st !== 9'b100000000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 100000000", st);
        end
        checks++;
        if ({wbuf_rd_addr, xbuf_rd_addr, ybuf_wr_addr} !== '0) begin
            errors++;
            $display("FAIL reset_addrs: got %h %h %h want 0", wbuf_rd_addr, xbuf_rd_addr, ybuf_wr_addr);
        end
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;
    endtask

    task automatic test_basic();
        int bad;
        run_cmd('h010, 'h100, 'h200, 4, 4, 0);
        bad = (wq.size() != SA_DIM);
        for (int k = 0; k < wq.size() && !bad; k++)
            if (wq[k] != exp_addr('h010, k) || wc[k] != acc_cyc + 1 + k) bad = 1;
        checks++;
        if (bad) begin errors++; $display("FAIL basic_wbuf: got %p at %p, accept %0d", wq, wc, acc_cyc); end
        checks++;
        if (lw_cnt != SA_DIM || lag_bad != 0) begin
            errors++; $display("FAIL basic_load_w: count %0d lag_bad %0d want 8 0", lw_cnt, lag_bad);
        end
        bad = (xq.size() != 4);
        for (int k = 0; k < xq.size() && !bad; k++) if (xq[k] != exp_addr('h100, k)) bad = 1;
        checks++;
        if (bad) begin errors++; $display("FAIL basic_xbuf: got %p want 100..103", xq); end
        bad = (yq.size() != 4);
        for (int k = 0; k < yq.size() && !bad; k++) if (yq[k] != exp_addr('h200, k)) bad = 1;
        checks++;
        if (bad) begin errors++; $display("FAIL basic_ybuf: got %p want 200..203", yq); end
        checks++;
        if (done_cnt != 1 || err_done !== 1'b0) begin
            errors++; $display("FAIL basic_done: pulses %0d err %b want 1 0", done_cnt, err_done);
        end
        // accept, +1 load start, 8 loads, 4 issues, 1 read lag, 3 SA lag, 1 exit
        checks++;
        if (done_cyc != acc_cyc + SA_DIM + 4 + 6) begin
            errors++; $display("FAIL basic_latency: done at +%0d want +%0d", done_cyc - acc_cyc, SA_DIM + 10);
        end
        checks++;
        if (rdy_bad != 0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL basic_ready: rdy_bad %0d ready %b want 0 1", rdy_bad, cmd_ready);
        end
    endtask

    task automatic test_stall();
        int bad;
        run_cmd('h010, 'h100, 'h200, 2, 2, 2);
        bad = (wq.size() != SA_DIM);
        for (int k = 0; k < wq.size() && !bad; k++) if (wq[k] != exp_addr('h010, k)) bad = 1;
        checks++;
        if (bad) begin errors++; $display("FAIL stall_wbuf: got %p want 10..17", wq); end
        checks++;
        if (wc.size() != SA_DIM || wc[3] - wc[2] != 4 || wc[2] - wc[0] != 2 || wc[7] - wc[3] != 4) begin
            errors++; $display("FAIL stall_gap: read cycles %p want 3-cycle hole before k=3", wc);
        end
        checks++;
        if (lw_cnt != SA_DIM || lag_bad != 0) begin
            errors++; $display("FAIL stall_load_w: count %0d lag_bad %0d want 8 0", lw_cnt, lag_bad);
        end
    endtask

    task automatic test_wrap();
        run_cmd('h3F0, 'h3FE, 'h3FF, 3, 3, 0);
        checks++;
        if (xq.size() != 3 || xq[0] != 'h3FE || xq[1] != 'h3FF || xq[2] != 'h000) begin
            errors++; $display("FAIL wrap_xbuf: got %p want 3fe 3ff 0", xq);
        end
        checks++;
        if (yq.size() != 3 || yq[0] != 'h3FF || yq[1] != 'h000 || yq[2] != 'h001) begin
            errors++; $display("FAIL wrap_ybuf: got %p want 3ff 0 1", yq);
        end
        checks++;
        if (wq.size() != SA_DIM || wq[7] != exp_addr('h3F0, 7)) begin
            errors++; $display("FAIL wrap_wbuf: got %p", wq);
        end
    endtask

    task automatic test_zero_rows();
        run_cmd('h055, 'h066, 'h077, 0, 0, 0);
        checks++;
        if (wq.size() + xq.size() + yq.size() != 0) begin
            errors++; $display("FAIL zero_traffic: w %0d x %0d y %0d want 0", wq.size(), xq.size(), yq.size());
        end
        checks++;
        if (done_cyc != acc_cyc + 1 || done_cnt != 1 || err_done !== 1'b1) begin
            errors++; $display("FAIL zero_done: at +%0d pulses %0d err %b want +1 1 1",
                               done_cyc - acc_cyc, done_cnt, err_done);
        end
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_sticky: err %b busy %b want 1 0", err, busy);
        end
        run_cmd('h000, 'h010, 'h020, 1, 1, 0);
        checks++;
        if (err_after_acc !== 1'b0 || err_done !== 1'b0 || yq.size() != 1) begin
            errors++; $display("FAIL zero_clear: err after accept %b at done %b writes %0d want 0 0 1",
                               err_after_acc, err_done, yq.size());
        end
    endtask

    task automatic test_timeout();
        int x, y;
        x = $urandom_range(0, 1023);
        y = $urandom_range(0, 1023);
        run_cmd('h100, x, y, 2, 1, 0);
        checks++;
        if (yq.size() != 1 || yq[0] != exp_addr(y, 0) || xq.size() != 2) begin
            errors++; $display("FAIL timeout_writes: y %p x %p want one write at %0h", yq, xq, y);
        end
        checks++;
        if (err_done !== 1'b1 || done_cnt != 1) begin
            errors++; $display("FAIL timeout_err: err %b pulses %0d want 1 1", err_done, done_cnt);
        end
        // last result, then 32 quiet drain cycles, then DONE
        checks++;
        if (yc.size() != 1 || done_cyc - yc[0] != TMO + 1) begin
            errors++; $display("FAIL timeout_delay: done %0d cycles after last result want %0d",
                               (yc.size() > 0) ? done_cyc - yc[0] : -1, TMO + 1);
        end
    endtask

    task automatic test_reset_mid();
        int cnt, bad;
        logic [5:0] st;
        wq.delete(); xq.delete(); yq.delete();
        replies_left = 0;
        @(posedge ACLK); #1;
        cmd_w_addr = 'h000; cmd_x_addr = 'h100; cmd_y_addr = 'h200; cmd_rows = 4; cmd_valid = 1'b1;
        @(posedge ACLK); #1;
        cmd_valid = 1'b0;
        cnt = 0;
        while (xq.size() != 1 && cnt < 100) begin @(posedge ACLK); #1; cnt++; end
        checks++;
        if (xq.size() != 1) begin errors++; $display("FAIL rmid_wait: xbuf reads %0d want 1", xq.size()); end
        #1 ARESET = 1'b1;
        #1;
        st = {wbuf_rd_en, xbuf_rd_en, ybuf_wr_en, sa_x_valid, cmd_ready, busy};
        checks++;
        if (st !== 6'b000010) begin errors++; $display("FAIL rmid_async: got %b want 000010", st); end
        @(negedge ACLK); #2 ARESET = 1'b0;
        @(posedge ACLK); #1;
        checks++;
        if (sa_x_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rmid_next: sa_x_valid %b busy %b want 0 0", sa_x_valid, busy);
        end
        repeat (4) @(posedge ACLK);
        run_cmd('h123, 'h234, 'h345, 3, 3, 0);
        bad = (xq.size() != 3 || yq.size() != 3);
        for (int k = 0; k < 3 && !bad; k++)
            if (xq[k] != exp_addr('h234, k) || yq[k] != exp_addr('h345, k)) bad = 1;
        checks++;
        if (bad || err_done !== 1'b0 || lw_cnt != SA_DIM) begin
            errors++; $display("FAIL rmid_rerun: x %p y %p err %b loads %0d", xq, yq, err_done, lw_cnt);
        end
    endtask

    task automatic test_random();
        int w, x, y, n, bad;
        for (int it = 0; it < 5; it++) begin
            w = $urandom_range(0, 1023);
            x = $urandom_range(0, 1023);
            y = $urandom_range(0, 1023);
            n = $urandom_range(1, 12);
            lag_bad = 0;
            run_cmd(w, x, y, n, n, 1);
            bad = (wq.size() != SA_DIM || xq.size() != n || yq.size() != n);
            for (int k = 0; k < SA_DIM && !bad; k++) if (wq[k] != exp_addr(w, k)) bad = 1;
            for (int k = 0; k < n && !bad; k++)
                if (xq[k] != exp_addr(x, k) || yq[k] != exp_addr(y, k)) bad = 1;
            checks++;
            if (bad) begin
                errors++; $display("FAIL rand_addrs[%0d]: w %p x %p y %p bases %0h %0h %0h n %0d",
                                   it, wq, xq, yq, w, x, y, n);
            end
            checks++;
            if (err_done !== 1'b0 || done_cnt != 1 || lw_cnt != SA_DIM || xv_cnt != n || lag_bad != 0) begin
                errors++; $display("FAIL rand_status[%0d]: err %b done %0d loads %0d xv %0d lag %0d want 0 1 8 %0d 0",
                                   it, err_done, done_cnt, lw_cnt, xv_cnt, lag_bad, n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_zero_rows();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
